mem_port_arbiter: RTL and testbench

Parametrised memory front-end that serves NCH requestor channels (instruction fetch, load/store, and later DMA or debug) through a single RAMHelper port. It replaces the pair of directly wired RAMHelper instances in the simulation top. Beyond the current wiring it adds:
- round-robin arbitration with a valid/ready handshake;
- byte/half/word/double sub-word stores with a generated write mask;
- aligned, sign- or zero-extended load data;
- misalignment error reporting.

---
 rtl/mem_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin front-end that shares one RAMHelper port among NCH requestors.
// Each transaction runs accept -> RAM access -> response, three cycles in all.
module mem_port_arbiter #(
  parameter int          NCH  = 2,
  parameter logic [63:0] BASE = 64'h8000_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NCH-1:0]    req_valid,
  output logic [NCH-1:0]    req_ready,
  input  logic [NCH*64-1:0] req_addr,
  input  logic [NCH-1:0]    req_wen,
  input  logic [NCH*2-1:0]  req_size,
  input  logic [NCH-1:0]    req_signed,
  input  logic [NCH*64-1:0] req_wdata,
  output logic [NCH-1:0]    resp_valid,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic [63:0]       ram_ridx,
  input  logic [63:0]       ram_rdata,
  output logic [63:0]       ram_widx,
  output logic [63:0]       ram_wdata,
  output logic [63:0]       ram_wmask,
  output logic              ram_wen
);

  // Handshake: a request is taken on a cycle where req_valid[k] && req_ready[k];
  // req_ready is one-hot, only in S_IDLE, and may be withdrawn freely by the requestor.

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] rr_ptr;
  logic [CW-1:0] gnt_id;
  logic          gnt_any;
  logic          accept;

  logic [CW-1:0] id_q;
  logic [63:0]   addr_q;
  logic [63:0]   idx_q;
  logic          wen_q;
  logic [1:0]    size_q;
  logic          signed_q;
  logic [63:0]   wdata_q;

  logic [63:0]   sel_addr;
  logic [2:0]    off;
  logic [5:0]    lane_shift;
  logic          misaligned;
  logic [63:0]   base_mask;
  logic [63:0]   sh;
  logic [63:0]   ext;

  // Search from rr_ptr upward, wrapping, for the first valid channel.
  always_comb begin
    int c;
    logic [CW-1:0] cand;
    c       = 0;
    cand    = '0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int i = 0; i < NCH; i++) begin
      c    = (int'(rr_ptr) + i) % NCH;
      cand = CW'(c);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  assign accept   = (state == S_IDLE) && gnt_any && !reset;
  assign sel_addr = req_addr[{gnt_id, 6'b000000} +: 64];

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_id] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      id_q     <= '0;
      addr_q   <= '0;
      idx_q    <= '0;
      wen_q    <= 1'b0;
      size_q   <= 2'd0;
      signed_q <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        id_q     <= gnt_id;
        addr_q   <= sel_addr;
        idx_q    <= (sel_addr - BASE) >> 3;
        wen_q    <= req_wen[gnt_id];
        size_q   <= req_size[{gnt_id, 1'b0} +: 2];
        signed_q <= req_signed[gnt_id];
        wdata_q  <= req_wdata[{gnt_id, 6'b000000} +: 64];
        rr_ptr   <= (gnt_id == CW'(NCH - 1)) ? '0 : gnt_id + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_MEM;
      S_MEM:   state_next = S_RESP;
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign off        = addr_q[2:0];
  assign lane_shift = {off, 3'b000};

  always_comb begin
    misaligned = 1'b0;
    base_mask  = 64'h0000_0000_0000_00ff;
    case (size_q)
      2'd0: begin misaligned = 1'b0;          base_mask = 64'h0000_0000_0000_00ff; end
      2'd1: begin misaligned = addr_q[0];     base_mask = 64'h0000_0000_0000_ffff; end
      2'd2: begin misaligned = |addr_q[1:0];  base_mask = 64'h0000_0000_ffff_ffff; end
      default: begin misaligned = |addr_q[2:0]; base_mask = 64'hffff_ffff_ffff_ffff; end
    endcase
  end

  // Load data: bring the addressed byte down to lane 0, then extend.
  assign sh = ram_rdata >> lane_shift;

  always_comb begin
    ext = '0;
    case (size_q)
      2'd0: ext = signed_q ? {{56{sh[7]}},  sh[7:0]}  : {56'd0, sh[7:0]};
      2'd1: ext = signed_q ? {{48{sh[15]}}, sh[15:0]} : {48'd0, sh[15:0]};
      2'd2: ext = signed_q ? {{32{sh[31]}}, sh[31:0]} : {32'd0, sh[31:0]};
      default: ext = sh;
    endcase
  end

  assign ram_ridx = idx_q;
  assign ram_widx = idx_q;

  always_comb begin
    ram_wen    = 1'b0;
    ram_wmask  = '0;
    ram_wdata  = '0;
    resp_valid = '0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    if (!reset && state == S_MEM && wen_q) begin
      ram_wdata = wdata_q << lane_shift;
      ram_wmask = base_mask << lane_shift;
      ram_wen   = !misaligned;
    end
    if (!reset && state == S_RESP) begin
      resp_valid[id_q] = 1'b1;
      resp_err         = misaligned;
      if (!wen_q && !misaligned) resp_rdata = ext;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table through a 2-channel instance
// backed by a small RAM model, plus contention/reset sequences and a 4-channel instance.
module tb_mem_port_arbiter;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         preload = 1'b1;

  logic [1:0]   req_valid = '0;
  logic [1:0]   req_ready;
  logic [127:0] req_addr = '0;
  logic [1:0]   req_wen = '0;
  logic [3:0]   req_size = '0;
  logic [1:0]   req_signed = '0;
  logic [127:0] req_wdata = '0;
  logic [1:0]   resp_valid;
  logic [63:0]  resp_rdata;
  logic         resp_err;
  logic [63:0]  ram_ridx, ram_rdata, ram_widx, ram_wdata, ram_wmask;
  logic         ram_wen;

  logic [3:0]   r4_valid = '0;
  logic [3:0]   r4_ready;
  logic [255:0] r4_addr = {4{64'h8000_0000}};
  logic [3:0]   r4_wen = '0;
  logic [7:0]   r4_size = {4{2'd3}};
  logic [3:0]   r4_signed = '0;
  logic [255:0] r4_wdata = '0;
  logic [3:0]   r4_resp_valid;
  logic [63:0]  r4_resp_rdata, r4_ridx, r4_widx, r4_wdata_o, r4_wmask;
  logic [63:0]  r4_rdata = '0;
  logic         r4_resp_err, r4_ram_wen;

  logic [63:0]  mem [0:63];
  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.NCH(2), .BASE(64'h8000_0000)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wen(req_wen), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .ram_ridx(ram_ridx), .ram_rdata(ram_rdata),
    .ram_widx(ram_widx), .ram_wdata(ram_wdata), .ram_wmask(ram_wmask),
    .ram_wen(ram_wen)
  );

  mem_port_arbiter #(.NCH(4), .BASE(64'h8000_0000)) dut4 (
    .clock(clock), .reset(reset),
    .req_valid(r4_valid), .req_ready(r4_ready), .req_addr(r4_addr),
    .req_wen(r4_wen), .req_size(r4_size), .req_signed(r4_signed),
    .req_wdata(r4_wdata), .resp_valid(r4_resp_valid), .resp_rdata(r4_resp_rdata),
    .resp_err(r4_resp_err), .ram_ridx(r4_ridx), .ram_rdata(r4_rdata),
    .ram_widx(r4_widx), .ram_wdata(r4_wdata_o), .ram_wmask(r4_wmask),
    .ram_wen(r4_ram_wen)
  );

  // RAM model: registered read, masked write.
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 64'd0;
      mem[0] <= 64'h8000_0000_0000_0000;
      mem[2] <= 64'h1122_3344_5566_7788;
      ram_rdata <= 64'd0;
    end else begin
      ram_rdata <= mem[ram_ridx[5:0]];
      if (ram_wen)
        mem[ram_widx[5:0]] <= (mem[ram_widx[5:0]] & ~ram_wmask) | (ram_wdata & ram_wmask);
    end
  end

  typedef struct {
    int          ch;
    logic [63:0] addr;
    logic        wen;
    logic [1:0]  size;
    logic        sgn;
    logic [63:0] wdata;
    logic [63:0] idx;
    logic        exp_wen;
    logic [63:0] wmask;
    logic [63:0] wd;
    logic        err;
    logic [63:0] rdata;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input int ch, input logic [63:0] a, input logic w,
                       input logic [1:0] s, input logic sg, input logic [63:0] wd);
    req_addr[ch*64 +: 64] = a;
    req_wen[ch]           = w;
    req_size[ch*2 +: 2]   = s;
    req_signed[ch]        = sg;
    req_wdata[ch*64 +: 64] = wd;
  endtask

  task automatic run_vec(input int n, input vec_t v);
    logic [1:0] want;
    bit got;
    want = 2'(1) << v.ch;
    got  = 1'b0;
    @(negedge clock);
    drive(v.ch, v.addr, v.wen, v.size, v.sgn, v.wdata);
    req_valid[v.ch] = 1'b1;
    for (int k = 0; k < 8 && !got; k++) begin
      #1;
      if (req_ready == want) got = 1'b1;
      else @(negedge clock);
    end
    chk($sformatf("v%0d accept", n), 64'(got), 64'd1);
    @(negedge clock);
    req_valid = '0;
    if (!got) return;
    #1;
    chk($sformatf("v%0d ridx", n), ram_ridx, v.idx);
    chk($sformatf("v%0d widx", n), ram_widx, v.idx);
    chk($sformatf("v%0d wen", n), 64'(ram_wen), 64'(v.exp_wen));
    if (v.wen) begin
      chk($sformatf("v%0d wmask", n), ram_wmask, v.wmask);
      chk($sformatf("v%0d wdata", n), ram_wdata, v.wd);
    end
    @(negedge clock);
    #1;
    chk($sformatf("v%0d resp_valid", n), 64'(resp_valid), 64'(want));
    chk($sformatf("v%0d resp_err", n), 64'(resp_err), 64'(v.err));
    chk($sformatf("v%0d rdata", n), resp_rdata, v.rdata);
  endtask

  function automatic vec_t mk(int ch, logic [63:0] a, logic w, logic [1:0] s, logic sg,
                              logic [63:0] wd, logic [63:0] idx, logic ew, logic [63:0] m,
                              logic [63:0] ewd, logic err, logic [63:0] rd);
    vec_t v;
    v.ch = ch; v.addr = a; v.wen = w; v.size = s; v.sgn = sg; v.wdata = wd;
    v.idx = idx; v.exp_wen = ew; v.wmask = m; v.wd = ewd; v.err = err; v.rdata = rd;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gch [8];
    int gcy [8];
    int ng;
    logic [3:0] bad4;

    vecs[0]  = mk(1, 64'h8000_0004, 0, 2, 1, 0, 0, 0, 0, 0, 0, 64'hffff_ffff_8000_0000);
    vecs[1]  = mk(0, 64'h8000_0013, 1, 0, 0, 64'hab, 2, 1, 64'h0000_0000_ff00_0000,
                  64'h0000_0000_ab00_0000, 0, 0);
    vecs[2]  = mk(0, 64'h8000_0010, 0, 3, 0, 0, 2, 0, 0, 0, 0, 64'h1122_3344_ab66_7788);
    vecs[3]  = mk(1, 64'h8000_0001, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    vecs[4]  = mk(0, 64'h8000_0004, 1, 3, 0, 64'h5555, 0, 0, 64'hffff_ffff_0000_0000,
                  64'h0000_5555_0000_0000, 1, 0);
    vecs[5]  = mk(1, 64'h8000_0012, 0, 1, 1, 0, 2, 0, 0, 0, 0, 64'hffff_ffff_ffff_ab66);
    vecs[6]  = mk(0, 64'h8000_0013, 0, 0, 0, 0, 2, 0, 0, 0, 0, 64'h0000_0000_0000_00ab);
    vecs[7]  = mk(1, 64'h8000_0013, 0, 0, 1, 0, 2, 0, 0, 0, 0, 64'hffff_ffff_ffff_ffab);
    vecs[8]  = mk(1, 64'h8000_001e, 1, 1, 0, 64'hbeef, 3, 1, 64'hffff_0000_0000_0000,
                  64'hbeef_0000_0000_0000, 0, 0);
    vecs[9]  = mk(0, 64'h8000_001c, 0, 2, 0, 0, 3, 0, 0, 0, 0, 64'h0000_0000_beef_0000);
    vecs[10] = mk(0, 64'h8000_0028, 1, 2, 0, 64'hdead_beef, 5, 1, 64'h0000_0000_ffff_ffff,
                  64'h0000_0000_dead_beef, 0, 0);
    vecs[11] = mk(1, 64'h8000_0028, 0, 3, 0, 0, 5, 0, 0, 0, 0, 64'h0000_0000_dead_beef);
    vecs[12] = mk(0, 64'h8000_0000, 0, 3, 0, 0, 0, 0, 0, 0, 0, 64'h8000_0000_0000_0000);
    vecs[13] = mk(1, 64'h8000_0030, 0, 3, 0, 0, 6, 0, 0, 0, 0, 64'd0);

    // Reset: ready must stay low even with requests pending.
    repeat (2) @(negedge clock);
    req_valid = 2'b11;
    #1;
    chk("reset ready", 64'(req_ready), 64'd0);
    @(negedge clock);
    req_valid = '0;
    reset = 1'b0;
    preload = 1'b0;
    #1;
    chk("reset resp_valid", 64'(resp_valid), 64'd0);
    chk("reset outputs", {resp_rdata | ram_wdata | ram_wmask | ram_ridx | ram_widx},
        64'd0);
    chk("reset wen/err", {62'd0, ram_wen, resp_err}, 64'd0);

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // Valid raised during a busy transaction and dropped before ready: no transaction.
    @(negedge clock);
    drive(0, 64'h8000_0000, 0, 3, 0, 0);
    req_valid[0] = 1'b1;
    #1;
    chk("drop accept0", 64'(req_ready), 64'd1);
    @(negedge clock);
    req_valid[0] = 1'b0;
    drive(1, 64'h8000_0010, 0, 3, 0, 0);
    req_valid[1] = 1'b1;
    #1;
    chk("drop busy ready", 64'(req_ready), 64'd0);
    @(negedge clock);
    req_valid[1] = 1'b0;
    #1;
    chk("drop resp", 64'(resp_valid), 64'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      #1;
      chk($sformatf("drop quiet %0d", k), {62'd0, req_ready} | {62'd0, resp_valid}, 64'd0);
    end

    // Reset during S_MEM of a store on channel 0 (leaves rr_ptr at 1 if not cleared).
    @(negedge clock);
    drive(0, 64'h8000_0030, 1, 3, 0, 64'h0123_4567_89ab_cdef);
    req_valid[0] = 1'b1;
    #1;
    chk("rst-store accept", 64'(req_ready), 64'd1);
    @(negedge clock);
    req_valid = '0;
    #1;
    chk("rst-store wen before", 64'(ram_wen), 64'd1);
    reset = 1'b1;
    #1;
    chk("rst-store wen gated", 64'(ram_wen), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst-store resp", 64'(resp_valid), 64'd0);
    chk("rst-store outputs", resp_rdata | ram_wdata | ram_wmask | ram_ridx, 64'd0);
    chk("rst-store wen after", {62'd0, ram_wen, resp_err}, 64'd0);

    // Contention on NCH=2: grants must alternate starting from channel 0.
    drive(0, 64'h8000_0000, 0, 3, 0, 0);
    drive(1, 64'h8000_0000, 0, 3, 0, 0);
    req_valid = 2'b11;
    ng = 0;
    for (int cy = 0; cy < 14; cy++) begin
      #1;
      if (req_ready != 2'b00 && ng < 8) begin
        gch[ng] = (req_ready == 2'b10) ? 1 : 0;
        gcy[ng] = cy;
        ng++;
      end
      @(negedge clock);
    end
    req_valid = '0;
    chk("contend count", 64'(ng >= 4), 64'd1);
    for (int k = 0; k < 4 && k < ng; k++) begin
      chk($sformatf("contend grant %0d", k), 64'(gch[k]), 64'(k % 2));
      if (k > 0) chk($sformatf("contend gap %0d", k), 64'(gcy[k] - gcy[k-1]), 64'd3);
    end
    repeat (3) @(negedge clock);

    // The aborted store must not have reached RAM index 6.
    run_vec(13, vecs[13]);

    // NCH=4 with only channels 1 and 3 requesting.
    @(negedge clock);
    r4_valid = 4'b1010;
    ng = 0;
    bad4 = '0;
    for (int cy = 0; cy < 14; cy++) begin
      #1;
      bad4 = bad4 | (r4_ready & 4'b0101);
      if (r4_ready != 4'b0000 && ng < 8) begin
        gch[ng] = (r4_ready == 4'b1000) ? 3 : (r4_ready == 4'b0010) ? 1 : -1;
        gcy[ng] = cy;
        ng++;
      end
      @(negedge clock);
    end
    r4_valid = '0;
    chk("nch4 count", 64'(ng >= 4), 64'd1);
    chk("nch4 idle channels readied", 64'(bad4), 64'd0);
    for (int k = 0; k < 4 && k < ng; k++) begin
      chk($sformatf("nch4 grant %0d", k), 64'(gch[k]), (k % 2 == 0) ? 64'd1 : 64'd3);
    end

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
